// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way write-back data cache controller.
package cache_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int SETS   = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FETCH,
        FILL
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_meta_t;

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set valid/dirty/tag/data, combinational read, 1-cycle write.
// Read and write share the set index; no backpressure.
module cache_way
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic [IDX_W-1:0]  idx,
    output line_meta_t        rd_meta,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  line_meta_t        wr_meta,
    input  logic [DATA_W-1:0] wr_data
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[idx] <= wr_meta.valid;
            dirty_q[idx] <= wr_meta.dirty;
        end
    end

    // Tag and data are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[idx]  <= wr_meta.tag;
            data_q[idx] <= wr_data;
        end
    end

    assign rd_meta.valid = valid_q[idx];
    assign rd_meta.dirty = dirty_q[idx];
    assign rd_meta.tag   = tag_q[idx];
    assign rd_data       = data_q[idx];

endmodule

// File: rtl/cache2vias_ctrl.sv
// Write-back, write-allocate 2-way cache controller with per-set LRU bit.
// Hit completes in LOOKUP; misses hold mem_req until mem_ack; cpu_req ignored while busy.
module cache2vias_ctrl
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              busy,
    output logic              hit,
    output logic              miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] fetch_q;
    logic              victim_q, victim_d;
    logic [SETS-1:0]   lru_q;
    logic              lru_set, lru_val;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    line_meta_t        meta0, meta1, vic_meta, sel_meta, wr_meta;
    logic [DATA_W-1:0] data0, data1, vic_data, wr_data;
    logic [1:0]        wr_en;
    logic              hit0, hit1, victim_sel;

    assign idx     = req_addr_q[IDX_W-1:0];
    assign req_tag = req_addr_q[ADDR_W-1:IDX_W];

    cache_way u_way0 (
        .clock(clock), .resetn(resetn), .idx(idx),
        .rd_meta(meta0), .rd_data(data0),
        .wr_en(wr_en[0]), .wr_meta(wr_meta), .wr_data(wr_data)
    );

    cache_way u_way1 (
        .clock(clock), .resetn(resetn), .idx(idx),
        .rd_meta(meta1), .rd_data(data1),
        .wr_en(wr_en[1]), .wr_meta(wr_meta), .wr_data(wr_data)
    );

    assign hit0       = meta0.valid && (meta0.tag == req_tag);
    assign hit1       = meta1.valid && (meta1.tag == req_tag);
    // Fill empty ways first so LRU only arbitrates between two live lines.
    assign victim_sel = !meta0.valid ? 1'b0 : (!meta1.valid ? 1'b1 : lru_q[idx]);
    assign sel_meta   = victim_sel ? meta1 : meta0;
    assign vic_meta   = victim_q ? meta1 : meta0;
    assign vic_data   = victim_q ? data1 : data0;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        hit         = 1'b0;
        miss        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wr_en       = 2'b00;
        wr_meta     = '0;
        wr_data     = '0;
        lru_set     = 1'b0;
        lru_val     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit0 || hit1) begin
                    hit       = 1'b1;
                    cpu_ready = 1'b1;
                    cpu_rdata = req_we_q ? req_wdata_q : (hit1 ? data1 : data0);
                    if (req_we_q) begin
                        wr_en[hit1]   = 1'b1;
                        wr_meta.valid = 1'b1;
                        wr_meta.dirty = 1'b1;
                        wr_meta.tag   = req_tag;
                        wr_data       = req_wdata_q;
                    end
                    lru_set = 1'b1;
                    lru_val = ~hit1;
                    state_d = IDLE;
                end else begin
                    miss     = 1'b1;
                    victim_d = victim_sel;
                    state_d  = (sel_meta.valid && sel_meta.dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vic_meta.tag, idx};
                mem_wdata = vic_data;
                if (mem_ack) state_d = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, idx};
                if (mem_ack) state_d = FILL;
            end
            FILL: begin
                wr_en[victim_q] = 1'b1;
                wr_meta.valid   = 1'b1;
                wr_meta.dirty   = req_we_q;
                wr_meta.tag     = req_tag;
                wr_data         = req_we_q ? req_wdata_q : fetch_q;
                cpu_ready       = 1'b1;
                cpu_rdata       = wr_data;
                lru_set         = 1'b1;
                lru_val         = ~victim_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            fetch_q     <= '0;
            victim_q    <= 1'b0;
            lru_q       <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (state_q == IDLE && cpu_req) begin
                req_we_q    <= cpu_we;
                req_addr_q  <= cpu_addr;
                req_wdata_q <= cpu_wdata;
            end
            if (state_q == FETCH && mem_ack) fetch_q <= mem_rdata;
            if (lru_set) lru_q[idx] <= lru_val;
        end
    end

endmodule
